// File: rtl/dmem_wb_slave_if.sv
// Wishbone-classic bus between the memory stage (master) and the data
// memory (slave).
//
// Handshake: the master drives dm_i_cyc and dm_i_stb together to request a
// transfer. The request is accepted on any rising edge where both are high
// and dm_o_stall is low. From that edge, dm_o_stall stays high until the
// transfer is over. The slave finishes with a one-cycle pulse on dm_o_ack
// (success) or dm_o_err (out-of-range address). The master must drop
// dm_i_stb once it sees stall; otherwise the request is taken again. If the
// master drops dm_i_cyc before the response, the transfer is abandoned.
interface dmem_wb_slave_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic                  dm_i_cyc;
  logic                  dm_i_stb;
  logic                  dm_i_we;
  logic [AWIDTH-1:0]     dm_i_addr;
  logic [DWIDTH-1:0]     dm_i_data;
  logic [DWIDTH/8-1:0]   dm_i_sel;
  logic [DWIDTH-1:0]     dm_o_data;
  logic                  dm_o_ack;
  logic                  dm_o_err;
  logic                  dm_o_stall;

  modport master (
    output dm_i_cyc, dm_i_stb, dm_i_we, dm_i_addr, dm_i_data, dm_i_sel,
    input  dm_o_data, dm_o_ack, dm_o_err, dm_o_stall
  );

  modport slave (
    input  dm_i_cyc, dm_i_stb, dm_i_we, dm_i_addr, dm_i_data, dm_i_sel,
    output dm_o_data, dm_o_ack, dm_o_err, dm_o_stall
  );
endinterface

// File: rtl/dmem_wb_slave.sv
// Single-beat Wishbone-classic data memory with configurable wait states,
// byte-select writes, registered read data and an error response for
// addresses beyond the implemented depth.
module dmem_wb_slave #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic         dm_clk,
  input  logic         dm_rst,
  dmem_wb_slave_if.slave bus,
  output logic [1:0]   dm_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int SW = DWIDTH / 8;
  // The counter must hold WAIT_STATES and is never narrower than one bit.
  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0]   WS_CNT  = CW'(WAIT_STATES);
  // One extra bit so that DEPTH == 2**AWIDTH is representable.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              accept;
  logic              finish;
  logic              in_range;
  logic              wr_en;

  logic [AWIDTH-1:0] lat_addr;
  logic              lat_we;
  logic [DWIDTH-1:0] lat_data;
  logic [SW-1:0]     lat_sel;

  logic [DWIDTH-1:0] rd_data;
  logic              ack_q;
  logic              err_q;

  // Storage starts at zero and is deliberately left alone by reset.
  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  assign in_range = ({1'b0, lat_addr} < DEPTH_W);

  // Next-state logic. WAIT always lasts WAIT_STATES+1 edges, so a request
  // accepted at edge N enters RESP (and raises ack/err) at edge
  // N+1+WAIT_STATES; dm_i_cyc is checked on every one of those edges.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.dm_i_cyc && bus.dm_i_stb) begin
          accept  = 1'b1;
          state_n = ST_WAIT;
          cnt_n   = WS_CNT;
        end
      end
      ST_WAIT: begin
        if (!bus.dm_i_cyc) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = ST_RESP;
          finish  = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and response registers; reset aborts any transfer.
  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rd_data <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack_q <= finish && in_range;
      err_q <= finish && !in_range;
      if (finish && in_range && !lat_we) begin
        rd_data <= mem[lat_addr];
      end
    end
  end

  // Capture the request on the accept edge; later bus values are ignored.
  always_ff @(posedge dm_clk) begin
    if (accept) begin
      lat_addr <= bus.dm_i_addr;
      lat_we   <= bus.dm_i_we;
      lat_data <= bus.dm_i_data;
      lat_sel  <= bus.dm_i_sel;
    end
  end

  assign wr_en = finish && in_range && lat_we && !dm_rst;

  // Byte-masked write into the array on the response edge.
  always_ff @(posedge dm_clk) begin
    if (wr_en) begin
      for (int i = 0; i < SW; i++) begin
        if (lat_sel[i]) begin
          mem[lat_addr][8*i +: 8] <= lat_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.dm_o_data  = rd_data;
  assign bus.dm_o_ack   = ack_q;
  assign bus.dm_o_err   = err_q;
  assign bus.dm_o_stall = (state != ST_IDLE);
  assign dm_dbg_state   = state;

endmodule

// File: tb/tb_dmem_wb_slave.sv
// Bench for dmem_wb_slave: three instances (WAIT_STATES 1/3/0, one with a
// short DEPTH) against a timeline-based reference model, with directed
// scenarios followed by fully random per-cycle bus traffic.
module tb_dmem_wb_slave;

  localparam int NI = 3;
  localparam int WS_P    [NI] = '{1, 3, 0};
  localparam int DEPTH_P [NI] = '{24, 32, 32};

  logic dm_clk = 1'b0;
  always #5 dm_clk = ~dm_clk;

  logic        rst   [NI];
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic [4:0]  addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  sel   [NI];
  logic [31:0] odata [NI];
  logic        ack   [NI];
  logic        err   [NI];
  logic        stall [NI];
  logic [1:0]  dbg   [NI];

  dmem_wb_slave_if #(.DWIDTH(32), .AWIDTH(5)) bus0 ();
  dmem_wb_slave_if #(.DWIDTH(32), .AWIDTH(5)) bus1 ();
  dmem_wb_slave_if #(.DWIDTH(32), .AWIDTH(5)) bus2 ();

  assign bus0.dm_i_cyc = cyc[0];  assign bus0.dm_i_stb = stb[0];
  assign bus0.dm_i_we  = we[0];   assign bus0.dm_i_addr = addr[0];
  assign bus0.dm_i_data = wdata[0]; assign bus0.dm_i_sel = sel[0];
  assign odata[0] = bus0.dm_o_data; assign ack[0] = bus0.dm_o_ack;
  assign err[0] = bus0.dm_o_err;    assign stall[0] = bus0.dm_o_stall;

  assign bus1.dm_i_cyc = cyc[1];  assign bus1.dm_i_stb = stb[1];
  assign bus1.dm_i_we  = we[1];   assign bus1.dm_i_addr = addr[1];
  assign bus1.dm_i_data = wdata[1]; assign bus1.dm_i_sel = sel[1];
  assign odata[1] = bus1.dm_o_data; assign ack[1] = bus1.dm_o_ack;
  assign err[1] = bus1.dm_o_err;    assign stall[1] = bus1.dm_o_stall;

  assign bus2.dm_i_cyc = cyc[2];  assign bus2.dm_i_stb = stb[2];
  assign bus2.dm_i_we  = we[2];   assign bus2.dm_i_addr = addr[2];
  assign bus2.dm_i_data = wdata[2]; assign bus2.dm_i_sel = sel[2];
  assign odata[2] = bus2.dm_o_data; assign ack[2] = bus2.dm_o_ack;
  assign err[2] = bus2.dm_o_err;    assign stall[2] = bus2.dm_o_stall;

  dmem_wb_slave #(.DWIDTH(32), .AWIDTH(5), .DEPTH(24), .WAIT_STATES(1)) u_dut0 (
    .dm_clk(dm_clk), .dm_rst(rst[0]), .bus(bus0.slave), .dm_dbg_state(dbg[0]));
  dmem_wb_slave #(.DWIDTH(32), .AWIDTH(5), .DEPTH(32), .WAIT_STATES(3)) u_dut1 (
    .dm_clk(dm_clk), .dm_rst(rst[1]), .bus(bus1.slave), .dm_dbg_state(dbg[1]));
  dmem_wb_slave #(.DWIDTH(32), .AWIDTH(5), .DEPTH(32), .WAIT_STATES(0)) u_dut2 (
    .dm_clk(dm_clk), .dm_rst(rst[2]), .bus(bus2.slave), .dm_dbg_state(dbg[2]));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: a request accepted at edge A answers at edge A+1+WS and
  // frees the slave at edge A+2+WS; cyc low on edges A+1..A+1+WS abandons it.
  int          edge_n = 0;
  logic [31:0] m_mem   [NI][32];
  bit          m_busy  [NI];
  int          m_acc   [NI];
  logic        m_we    [NI];
  logic [4:0]  m_addr  [NI];
  logic [31:0] m_data  [NI];
  logic [3:0]  m_sel   [NI];
  logic [31:0] e_data  [NI];
  logic        e_ack   [NI];
  logic        e_err   [NI];
  logic        e_stall [NI];

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int ph;
      if (rst[k]) begin
        m_busy[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
        e_stall[k] = 1'b0; e_data[k] = 32'h0;
        continue;
      end
      e_ack[k] = 1'b0;
      e_err[k] = 1'b0;
      if (!m_busy[k]) begin
        if (cyc[k] && stb[k]) begin
          m_busy[k] = 1'b1; m_acc[k] = edge_n; e_stall[k] = 1'b1;
          m_we[k] = we[k]; m_addr[k] = addr[k]; m_data[k] = wdata[k]; m_sel[k] = sel[k];
        end
      end else begin
        ph = edge_n - m_acc[k];
        if (ph <= WS_P[k] + 1 && !cyc[k]) begin
          m_busy[k] = 1'b0; e_stall[k] = 1'b0;
        end else if (ph == WS_P[k] + 1) begin
          if (int'(m_addr[k]) < DEPTH_P[k]) begin
            e_ack[k] = 1'b1;
            if (m_we[k]) begin
              for (int b = 0; b < 4; b++)
                if (m_sel[k][b]) m_mem[k][m_addr[k]][8*b +: 8] = m_data[k][8*b +: 8];
            end else begin
              e_data[k] = m_mem[k][m_addr[k]];
            end
          end else begin
            e_err[k] = 1'b1;
          end
        end else if (ph == WS_P[k] + 2) begin
          m_busy[k] = 1'b0; e_stall[k] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  initial begin
    for (int k = 0; k < NI; k++)
      for (int a = 0; a < 32; a++) m_mem[k][a] = 32'h0;
    forever begin
      @(posedge dm_clk);
      model_step();
    end
  end

  // Compare every output of every instance on each falling edge.
  initial begin
    forever begin
      @(negedge dm_clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          check($sformatf("ack%0d", k),   32'(ack[k]),   32'(e_ack[k]));
          check($sformatf("err%0d", k),   32'(err[k]),   32'(e_err[k]));
          check($sformatf("stall%0d", k), 32'(stall[k]), 32'(e_stall[k]));
          check($sformatf("data%0d", k),  odata[k],      e_data[k]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge dm_clk);
    #1;
  endtask

  // One complete transfer on an idle slave; reports latency (edges after
  // the accept edge until ack/err is visible, -1 on timeout).
  task automatic bus_req(input int k, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic g_ack, output logic g_err,
                         output logic [31:0] g_data, output logic g_stall);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; sel[k] = s;
    tick();
    g_stall = stall[k];
    stb[k] = 1'b0;
    lat = -1; g_ack = 1'b0; g_err = 1'b0; g_data = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ack[k] || err[k]) begin
        lat = i; g_ack = ack[k]; g_err = err[k]; g_data = odata[k];
        break;
      end
    end
    cyc[k] = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic        g_ack, g_err, g_stall;
    logic [31:0] g_data;

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 5'd0; wdata[k] = 32'h0; sel[k] = 4'h0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    check("rst_data", odata[0], 32'h0);
    check("rst_ack", 32'(ack[0]), 32'h0);
    check("rst_err", 32'(err[0]), 32'h0);
    check("rst_stall", 32'(stall[0]), 32'h0);
    tick();

    // WAIT_STATES=1, DEPTH=24
    bus_req(0, 1'b1, 5'd10, 32'h0000000E, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    check("w10_lat", 32'(lat), 32'd2);
    check("w10_ack", 32'(g_ack), 32'd1);
    check("w10_stall_acc", 32'(g_stall), 32'd1);
    check("w10_stall_end", 32'(stall[0]), 32'd0);
    bus_req(0, 1'b0, 5'd10, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("r10_lat", 32'(lat), 32'd2);
    check("r10_data", g_data, 32'h0000000E);
    check("r10_hold", odata[0], 32'h0000000E);
    bus_req(0, 1'b1, 5'd3, 32'hAABBCCDD, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    bus_req(0, 1'b1, 5'd3, 32'h11223344, 4'h5, lat, g_ack, g_err, g_data, g_stall);
    check("w3_keeps_rdata", odata[0], 32'h0000000E);
    bus_req(0, 1'b0, 5'd3, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("r3_merge", g_data, 32'hAA22CC44);
    bus_req(0, 1'b1, 5'd31, 32'hDEADBEEF, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    check("w31_lat", 32'(lat), 32'd2);
    check("w31_err", 32'(g_err), 32'd1);
    check("w31_noack", 32'(g_ack), 32'd0);
    bus_req(0, 1'b0, 5'd31, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("r31_err", 32'(g_err), 32'd1);
    check("r31_data", odata[0], 32'hAA22CC44);
    bus_req(0, 1'b1, 5'd0, 32'h01020304, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("sel0_ack", 32'(g_ack), 32'd1);
    bus_req(0, 1'b0, 5'd0, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("sel0_data", g_data, 32'h0);

    // WAIT_STATES=3: abandoned write
    bus_req(1, 1'b1, 5'd7, 32'h5A5A5A5A, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    check("ws3_lat", 32'(lat), 32'd4);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd7; wdata[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
    tick();
    check("abort_stall_acc", 32'(stall[1]), 32'd1);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    tick();
    check("abort_stall", 32'(stall[1]), 32'd0);
    repeat (5) tick();
    bus_req(1, 1'b0, 5'd7, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("abort_mem", g_data, 32'h5A5A5A5A);

    // WAIT_STATES=3: reset in WAIT
    bus_req(1, 1'b1, 5'd5, 32'hCAFEF00D, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd5; wdata[1] = 32'h12345678; sel[1] = 4'hF;
    tick();
    stb[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0; cyc[1] = 1'b0;
    check("rstw_data", odata[1], 32'h0);
    check("rstw_stall", 32'(stall[1]), 32'd0);
    check("rstw_ack", 32'(ack[1]), 32'd0);
    repeat (6) tick();
    bus_req(1, 1'b0, 5'd5, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("rstw_mem", g_data, 32'hCAFEF00D);

    // WAIT_STATES=0
    bus_req(2, 1'b1, 5'd1, 32'h0BADBEEF, 4'hF, lat, g_ack, g_err, g_data, g_stall);
    check("ws0_wlat", 32'(lat), 32'd1);
    bus_req(2, 1'b0, 5'd1, 32'h0, 4'h0, lat, g_ack, g_err, g_data, g_stall);
    check("ws0_rlat", 32'(lat), 32'd1);
    check("ws0_rdata", g_data, 32'h0BADBEEF);

    // Random per-cycle traffic on all instances, including stb without
    // cyc, held strobes, abandoned transfers and occasional resets.
    repeat (3000) begin
      for (int k = 0; k < NI; k++) begin
        rst[k]   = ($urandom_range(0, 199) == 0);
        cyc[k]   = ($urandom_range(0, 99) < 85);
        stb[k]   = ($urandom_range(0, 99) < 50);
        we[k]    = 1'($urandom_range(0, 1));
        addr[k]  = 5'($urandom_range(0, 31));
        wdata[k] = $urandom;
        sel[k]   = 4'($urandom_range(0, 15));
      end
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
    end
    repeat (8) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
